// File: rtl/simd_isa_pkg.sv
// Shared ISA definitions for the SIMD encoder/decoder pair: type codes,
// opcode fields and the fixed RET word.
package simd_isa_pkg;

    typedef enum logic [2:0] {
        T_ADD  = 3'b000,
        T_SUB  = 3'b001,
        T_MUL  = 3'b010,
        T_UDIV = 3'b011,
        T_FADD = 3'b100,
        T_FSUB = 3'b101,
        T_LOAD = 3'b110,
        T_RET  = 3'b111
    } instr_type_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_MUL  = 11'b10011011000;
    localparam logic [10:0] OP_UDIV = 11'b10011010110;
    localparam logic [10:0] OP_FP   = 11'b00011110011;
    localparam logic [10:0] OP_LOAD = 11'b10101010101;

    localparam logic [5:0] FN_FADD = 6'b001010;
    localparam logic [5:0] FN_FSUB = 6'b001110;

    localparam logic [31:0] RET_WORD = 32'hD65F03C0;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TERM = 2'd1,
        S_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/simd_instr_pack.sv
// Combinational packer: decoded instruction fields to one 32-bit ISA word.
module simd_instr_pack
    import simd_isa_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [5:0]  shamt_i,
    input  logic [8:0]  addr_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = RET_WORD;
        case (type_i)
            T_ADD:  word_o = {OP_ADD,  rm_i, shamt_i, rn_i, rd_i};
            T_SUB:  word_o = {OP_SUB,  rm_i, shamt_i, rn_i, rd_i};
            T_MUL:  word_o = {OP_MUL,  rm_i, shamt_i, rn_i, rd_i};
            T_UDIV: word_o = {OP_UDIV, rm_i, shamt_i, rn_i, rd_i};
            // FP ops carry a fixed function field where R-type has the shift.
            T_FADD: word_o = {OP_FP,   rm_i, FN_FADD, rn_i, rd_i};
            T_FSUB: word_o = {OP_FP,   rm_i, FN_FSUB, rn_i, rd_i};
            T_LOAD: word_o = {OP_LOAD, addr_i, 2'b00, rn_i, rd_i};
            default: word_o = RET_WORD;
        endcase
    end

endmodule

// File: rtl/simd_program_encoder.sv
// Packs a stream of decoded instructions into sequential instruction-memory
// writes, terminates the program with RET and reports its length.
module simd_program_encoder
    import simd_isa_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_type,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [5:0]    in_shamt,
    input  logic [8:0]    in_addr,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   prog_len,
    output logic          done,
    output logic          overflow,
    output enc_state_e    dbg_state
);

    // Handshake: a bundle transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid.

    localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

    enc_state_e    state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   packed_word;
    logic          accept;

    simd_instr_pack u_pack (
        .type_i  (in_type),
        .rd_i    (in_rd),
        .rn_i    (in_rn),
        .rm_i    (in_rm),
        .shamt_i (in_shamt),
        .addr_i  (in_addr),
        .word_o  (packed_word)
    );

    // The last slot is reserved for the terminating RET.
    assign in_ready = rst_n && !clear && (state_q == S_RUN) && (ptr_q < LAST_SLOT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = S_RUN;
            ptr_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (accept) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q[AW-1:0];
                        wdata_d = packed_word;
                        ptr_d   = ptr_q + (AW+1)'(1);
                        if (in_type == T_RET) begin
                            state_d = S_DONE;
                        end else if (in_last) begin
                            state_d = S_TERM;
                        end
                    end else if (in_valid && (ptr_q == LAST_SLOT)) begin
                        ovf_d   = 1'b1;
                        state_d = S_TERM;
                    end
                end
                S_TERM: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[AW-1:0];
                    wdata_d = RET_WORD;
                    ptr_d   = ptr_q + (AW+1)'(1);
                    state_d = S_DONE;
                end
                S_DONE: begin
                    // Raised one cycle after entry so it follows the RET write.
                    done_d = 1'b1;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign prog_len   = ptr_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_simd_program_encoder.sv
// Bench for simd_program_encoder: directed and random programs checked
// through an expected-write queue against a field-level encoding model.
module tb_simd_program_encoder;
    import simd_isa_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int W     = AW + 32;

    typedef struct {
        logic [2:0] typ;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [5:0] shamt;
        logic [8:0] addr;
    } bundle_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_type = '0;
    logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0;
    logic [5:0]    in_shamt = '0;
    logic [8:0]    in_addr = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   prog_len;
    logic          done;
    logic          overflow;
    enc_state_e    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           n;
    bit           m_done;
    bit           m_ovf;

    simd_program_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_shamt(in_shamt),
        .in_addr(in_addr), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .prog_len(prog_len), .done(done), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- reference model: ISA word from the field rules ----
    function automatic logic [31:0] ref_word(input bundle_t b);
        case (b.typ)
            3'd0: return {11'b10001011000, b.rm, b.shamt, b.rn, b.rd};
            3'd1: return {11'b11001011000, b.rm, b.shamt, b.rn, b.rd};
            3'd2: return {11'b10011011000, b.rm, b.shamt, b.rn, b.rd};
            3'd3: return {11'b10011010110, b.rm, b.shamt, b.rn, b.rd};
            3'd4: return {11'b00011110011, b.rm, 6'b001010, b.rn, b.rd};
            3'd5: return {11'b00011110011, b.rm, 6'b001110, b.rn, b.rd};
            3'd6: return {11'b10101010101, b.addr, 2'b00, b.rn, b.rd};
            default: return 32'hD65F03C0;
        endcase
    endfunction

    function automatic bundle_t mk(input int t, rd, rn, rm, sh, ad);
        bundle_t b;
        b.typ = 3'(t); b.rd = 5'(rd); b.rn = 5'(rn); b.rm = 5'(rm);
        b.shamt = 6'(sh); b.addr = 9'(ad);
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        int t;
        t = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
        return mk(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 63), $urandom_range(0, 511));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_q.push_back({AW'(n), w});
        n++;
    endtask

    // ---- driver: offer one bundle for one cycle ----
    task automatic offer(input bundle_t b, input bit last, input logic [31:0] w);
        bit exp_rdy;
        @(negedge clk);
        in_type = b.typ; in_rd = b.rd; in_rn = b.rn; in_rm = b.rm;
        in_shamt = b.shamt; in_addr = b.addr; in_last = last; in_valid = 1'b1;
        exp_rdy = !m_done && (n < DEPTH - 1);
        #1 chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy) begin
            push_exp(w);
            if (b.typ == 3'd7) m_done = 1'b1;
            else if (last) begin
                push_exp(32'hD65F03C0);
                m_done = 1'b1;
            end
        end else if (!m_done) begin
            push_exp(32'hD65F03C0);
            m_done = 1'b1;
            m_ovf  = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic end_check();
        idle(4);
        chk("done", 64'(done), 64'(m_done));
        chk("prog_len_final", 64'(prog_len), 64'(n));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("in_ready_after_end", 64'(in_ready), 64'(0));
        chk("imem_we_idle", 64'(imem_we), 64'(0));
        chk("pending_writes", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic model_reset();
        exp_q.delete();
        n = 0; m_done = 1'b0; m_ovf = 1'b0;
    endtask

    // clear is held together with a valid bundle, which must not transfer
    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_type = 3'd0; in_last = 1'b0;
        #1 chk("in_ready_under_clear", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("clear_prog_len", 64'(prog_len), 64'(0));
        chk("clear_done", 64'(done), 64'(0));
        chk("clear_overflow", 64'(overflow), 64'(0));
        chk("clear_imem_we", 64'(imem_we), 64'(0));
        chk("clear_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_imem_we"}, 64'(imem_we), 64'(0));
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
        chk({tag, "_prog_len"}, 64'(prog_len), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        bundle_t b;
        int len;
        model_reset();

        // ---- monitor / scoreboard ----
        fork
            forever begin
                @(negedge clk);
                if (rst_n && imem_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'({imem_addr, imem_wdata}), 64'(0));
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        chk("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(e));
                        chk("prog_len_at_write", 64'(prog_len), 64'(e[W-1:32]) + 64'(1));
                    end
                end
            end
        join_none

        // ---- reset ----
        #3 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_release", 64'(in_ready), 64'(1));

        // ADD, then clear
        offer(mk(0, 1, 2, 3, 0, 0), 1'b0, 32'h8B030041);
        do_clear();

        // FADD then MUL back-to-back, LOAD closes the program
        offer(mk(4, 0, 1, 2, 63, 0), 1'b0, 32'h1E622820);
        offer(mk(2, 4, 4, 4, 0, 0), 1'b0, 32'h9B040084);
        offer(mk(6, 5, 0, 31, 0, 9'h1FF), 1'b1, 32'hAABFF005);
        end_check();
        do_clear();

        // SUB with in_last gets an appended RET
        offer(mk(1, 2, 3, 4, 0, 0), 1'b1, 32'hCB040062);
        end_check();
        do_clear();

        // fill to the RET slot, then one more request overflows
        for (int i = 0; i < DEPTH; i++) begin
            b = rand_bundle();
            b.typ = 3'($urandom_range(0, 6));
            offer(b, 1'b0, ref_word(b));
        end
        end_check();
        do_clear();

        // explicit RET: no duplicate
        offer(mk(3, 9, 10, 11, 5, 0), 1'b0, ref_word(mk(3, 9, 10, 11, 5, 0)));
        offer(mk(7, 1, 1, 1, 1, 1), 1'b1, 32'hD65F03C0);
        end_check();
        do_clear();

        // async reset mid-stream after two writes
        offer(mk(0, 1, 1, 1, 1, 0), 1'b0, ref_word(mk(0, 1, 1, 1, 1, 0)));
        offer(mk(1, 2, 2, 2, 2, 0), 1'b0, ref_word(mk(1, 2, 2, 2, 2, 0)));
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_midreset", 64'(in_ready), 64'(1));
        offer(mk(0, 7, 8, 9, 3, 0), 1'b1, ref_word(mk(0, 7, 8, 9, 3, 0)));
        end_check();
        do_clear();

        // random programs
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < len && !m_done; i++) begin
                b = rand_bundle();
                idle($urandom_range(0, 2));
                offer(b, (i == len - 1), ref_word(b));
            end
            if (!m_done) begin
                b = mk(7, 0, 0, 0, 0, 0);
                offer(b, 1'b1, 32'hD65F03C0);
            end
            end_check();
            do_clear();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---- watchdog ----
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simd_program_encoder.md
# simd_program_encoder

Encoding-side counterpart to the SIMD instruction decoder. It accepts decoded instruction fields (type code, registers, shift amount, load address) over a valid/ready handshake and packs each one into the 32-bit ISA word. It writes the words sequentially into instruction memory, appends a terminating RET, and reports program length. It sits between the host/loader path and the SIMD core's instruction memory write port.

## Interface
- DEPTH, 64: instruction memory words; power of two, ≥ 2
- AW, $clog2(DEPTH): memory address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart to empty program
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept bundle
- in_type  in  3  000 ADD, 001 SUB, 010 MUL, 011 UDIV, 100 FADD, 101 FSUB, 110 LOAD, 111 RET
- in_rd / in_rn / in_rm  in  5 each  dest / source1 / source2 register
- in_shamt  in  6  shift field (R-type only)
- in_addr  in  9  load address (LOAD only)
- in_last  in  1  final instruction of program
- imem_we  out  1  memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  32  encoded word
- prog_len  out  AW+1  words written, including RET
- done  out  1  program terminated; sticky until clear
- overflow  out  1  sticky: request arrived with only RET slot left

## Operation
- Packing. Rd sits in [4:0] and Rn in [9:5].
  - ADD/SUB/MUL/UDIV: [31:21] = 10001011000 / 11001011000 / 10011011000 / 10011010110; [20:16]=rm; [15:10]=shamt.
  - FADD/FSUB: [31:21]=00011110011; [20:16]=rm; [15:10] forced to 001010 / 001110; in_shamt ignored.
  - LOAD: [31:21]=10101010101; [20:12]=addr; [11:10]=00; rm and shamt ignored.
  - RET: constant 0xD65F03C0; all fields ignored.
- FSM states:
  - RUN: in_ready = !clear && ptr < DEPTH-1.
    - Handshake → write word at ptr, ptr++.
    - If accepted with in_last=1 and type≠111 → TERM.
    - If accepted with type 111 → DONE; no extra RET is written.
    - If in_valid=1 while ptr==DEPTH-1 → overflow=1 and go to TERM; the request is dropped.
  - TERM: in_ready=0; write RET at ptr, ptr++ → DONE.
  - DONE: in_ready=0, done=1. Held until clear.
- Clear, any state:
  - ptr=0, overflow=0, done=0, imem_we=0, state=RUN.
  - clear overrides any handshake in the same cycle.
- prog_len always equals ptr.
- Reset values: in_ready=0 while rst_n low, then 1 from the first cycle after release. imem_we=0, imem_addr=0, imem_wdata=0, prog_len=0, done=0, overflow=0, state=RUN.

## Timing
- Write path fully registered: a handshake at edge k drives imem_we=1 with addr/data during cycle k→k+1; memory samples at edge k+1.
- Throughput: one instruction per cycle, with no bubbles in RUN.
- in_last at edge k: in_ready low from edge k. RET driven during cycle k+1→k+2. done=1 and final prog_len visible after edge k+2.
- Overflow detect at edge k: overflow=1 after edge k. RET written at address DEPTH-1 in the following cycle. done=1 after edge k+2.
- imem_we is low in every cycle without a write.
- Async reset mid-program: all outputs drop to reset values immediately. Memory contents are left as-is; the program is abandoned.

## Structure
- simd_isa_pkg: 3-bit type-code enum, the 11-bit opcode constants, FADD/FSUB function fields, and RET_WORD. The decoder will be moved onto the same package.
- Sub-module simd_instr_pack: purely combinational, fields → 32-bit word.
- Top module: FSM, pointer, and output registers.

## Test plan
- ADD rd=1 rn=2 rm=3 shamt=0 → imem_wdata=0x8B030041 at addr 0, we for one cycle, prog_len=1.
- FADD rd=0 rn=1 rm=2 shamt=0x3F → 0x1E622820 (shamt ignored). Back-to-back with MUL rd=4 rn=4 rm=4 → 0x9B040084 in the next cycle at addr 1.
- LOAD rd=5 rn=0 addr=0x1FF rm=0x1F → 0xAABFF005.
- SUB rd=2 rn=3 rm=4 with in_last at addr 0 → 0xCB040062 at 0, RET 0xD65F03C0 at 1, done=1, prog_len=2, in_ready stays 0.
- DEPTH=4: three accepted words, fourth held valid → in_ready 0, overflow=1, RET at addr 3, prog_len=4. Explicit type 111 gives a single RET with no duplicate.
- rst_n pulsed low mid-stream after 2 writes → all outputs 0 immediately. After release, the first write lands at addr 0. clear in DONE restarts identically.
